demux16_regbank: RTL and testbench
==================================

DEMUX16_REGBANK -- requirements
Module: demux16_regbank

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data width of each register.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, the asynchronous, active-low reset.
REQ-004 The module SHALL have port wr_valid, input, 1, the write request valid.
REQ-005 The module SHALL have port wr_ready, output, 1, the write request accepted this cycle.
REQ-006 The module SHALL have port wr_addr, input, 4, the destination register index 0-15.
REQ-007 The module SHALL have port wr_data, input, WIDTH, the write data.
REQ-008 The module SHALL have port hold, input, 1, the commit freeze (pipeline stall).
REQ-009 The module SHALL have port rd_addr, input, 4, the read register index.
REQ-010 The module SHALL have port rd_data, output, WIDTH, the read data (combinational).
REQ-011 The module SHALL have port wr_strobe, output, 16, the registered one-hot commit indicator.
REQ-012 The module SHALL have port wr_count, output, 8, the count of committed writes.

Function
REQ-013 The module SHALL contain 16 registers of WIDTH bits, plus a one-entry staging register (stage_valid, stage_addr, stage_data).
REQ-014 The module SHALL drive wr_ready = !stage_valid || !hold, combinationally.
REQ-015 The module SHALL treat a write as accepted on an edge where wr_valid && wr_ready, and on that edge latch wr_addr/wr_data into the staging register and set stage_valid.
REQ-016 The module SHALL perform a commit on an edge where stage_valid && !hold, writing stage_data into register[stage_addr]; all other registers are unchanged.
REQ-017 The module SHALL, for acceptance and commit on the same edge, commit the old staged entry and load the new one, with stage_valid remaining 1; throughput is one write per cycle while hold=0.
REQ-018 The module SHALL clear stage_valid on a commit edge with no simultaneous acceptance.
REQ-019 The module SHALL keep the staging register and stage_valid unchanged while hold=1 and stage_valid=1; wr_ready=0 and new requests wait.
REQ-020 The module SHALL accept a request while hold=1 and stage_valid=0 (wr_ready=1), and hold it staged until hold falls.
REQ-021 The module SHALL set wr_strobe to one-hot(stage_addr) on a commit edge and to 0 on every other edge; the strobe is high for exactly one cycle per commit.
REQ-022 The module SHALL increment wr_count by 1 per commit, modulo 256 (255 -> 0 wrap).
REQ-023 The module SHALL drive rd_data = stage_data when stage_valid && stage_addr == rd_addr (forwarding), else register[rd_addr].
REQ-024 The module SHALL treat consecutive writes to the same address as last-writer-wins in commit order; forwarding always shows the newest staged value.
REQ-025 The module SHALL ignore wr_addr/wr_data when wr_valid=0; no state change.

Reset
REQ-026 The module SHALL, while reset_n=0, immediately and asynchronously force all 16 registers to 0, stage_valid=0, wr_strobe=0, and wr_count=0; rd_data reads 0.
REQ-027 The module SHALL discard a write staged when reset asserts (no commit, no strobe, no count).
REQ-028 The module SHALL accept writes from the first rising edge with reset_n=1.

Verification
REQ-029 The bench SHALL cover: reset, then write r5=16'hBEEF with hold=0 -> wr_strobe=16'h0020 for 1 cycle; wr_count=1; rd_addr=5 reads BEEF at and after the commit edge.
REQ-030 The bench SHALL cover: back-to-back writes r0=1, r15=2, r0=3 on consecutive cycles with hold=0 -> wr_ready stays 1; strobes 0001, 8000, 0001; final r0=3, r15=2, wr_count=3.
REQ-031 The bench SHALL cover: hold=1, write r7=16'h1234 -> accepted, next cycle wr_ready=0, no strobe, rd_addr=7 forwards 1234; release hold -> commit, strobe 0080, wr_ready=1.
REQ-032 The bench SHALL cover: 256 commits from reset -> wr_count wraps to 0; 257th -> 1.
REQ-033 The bench SHALL cover: stage write r3=16'hAAAA with hold=1, pulse reset_n low mid-cycle -> outputs zero immediately; after release r3 reads 0, wr_count=0, no strobe.
REQ-034 The bench SHALL cover: wr_valid=0 with changing wr_addr/wr_data for 10 cycles -> no register, strobe or count change.

Source files
------------

// File: rtl/demux16_regbank.sv
// Sixteen-entry register bank fed through a one-deep staging register, with read forwarding.
// Latency: a write is accepted on one edge and committed on the next edge unless hold is high.
// Backpressure: wr_ready drops only while an entry is staged and hold freezes commits.
module demux16_regbank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hold,
    input  logic [3:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [15:0]      wr_strobe,
    output logic [7:0]       wr_count
);

    logic [WIDTH-1:0] regs_q [16];
    logic [WIDTH-1:0] regs_d [16];

    logic             stage_vld_q,  stage_vld_d;
    logic [3:0]       stage_addr_q, stage_addr_d;
    logic [WIDTH-1:0] stage_data_q, stage_data_d;
    logic [15:0]      strobe_q,     strobe_d;
    logic [7:0]       count_q,      count_d;

    logic accept;
    logic commit;

    // The staging slot is free either when empty or when it drains on this same edge.
    assign wr_ready = !stage_vld_q || !hold;
    assign accept   = wr_valid && wr_ready;
    assign commit   = stage_vld_q && !hold;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        stage_vld_d  = stage_vld_q;
        stage_addr_d = stage_addr_q;
        stage_data_d = stage_data_q;
        strobe_d     = 16'h0000;
        count_d      = count_q;

        if (commit) begin
            regs_d[stage_addr_q] = stage_data_q;
            strobe_d             = 16'h0001 << stage_addr_q;
            count_d              = count_q + 8'd1;
            stage_vld_d          = 1'b0;
        end

        // A new acceptance overrides the clear above, keeping the slot full.
        if (accept) begin
            stage_vld_d  = 1'b1;
            stage_addr_d = wr_addr;
            stage_data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
            stage_vld_q  <= 1'b0;
            stage_addr_q <= 4'd0;
            stage_data_q <= '0;
            strobe_q     <= 16'h0000;
            count_q      <= 8'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
            stage_vld_q  <= stage_vld_d;
            stage_addr_q <= stage_addr_d;
            stage_data_q <= stage_data_d;
            strobe_q     <= strobe_d;
            count_q      <= count_d;
        end
    end

    // Forward the staged value so a read never sees data older than the last accepted write.
    always_comb begin
        rd_data = regs_q[rd_addr];
        if (stage_vld_q && (stage_addr_q == rd_addr)) begin
            rd_data = stage_data_q;
        end
    end

    assign wr_strobe = strobe_q;
    assign wr_count  = count_q;

endmodule

// File: tb/tb_demux16_regbank.sv
// Scoreboard bench for demux16_regbank: accepted writes are queued, commits pop and check them.
module tb_demux16_regbank;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hold;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] wr_strobe;
    logic [7:0]  wr_count;

    int checks = 0;
    int errors = 0;

    wr_t         sb [$];
    logic [15:0] model_mem [16];
    logic [7:0]  model_cnt;

    demux16_regbank #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hold      (hold),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_strobe (wr_strobe),
        .wr_count  (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        model_cnt = 8'd0;
    endtask

    // Commit monitor: every strobe must match the oldest accepted write.
    always @(negedge clk) begin
        if (reset_n && wr_strobe != 16'h0000) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", 32'(wr_strobe), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("strobe", 32'(wr_strobe), 32'(16'h0001 << e.a));
                model_mem[e.a] = e.d;
                model_cnt      = model_cnt + 8'd1;
                chk("count_at_commit", 32'(wr_count), 32'(model_cnt));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        hold     = 1'b0;
        reset_n  = 1'b0;
        clear_model();
        #3;
        reset_n = 1'b1;
        sync();
    endtask

    // Presents a write and holds it until accepted; returns the cycles spent waiting.
    task automatic do_write(input logic [3:0] a, input logic [15:0] d, output int waited);
        wr_t e;
        logic ok;
        waited   = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        ok = wr_ready;
        if (!ok) chk("accept_timeout", 32'(wr_ready), 32'd1);
        @(posedge clk);
        if (ok) begin
            e.a = a;
            e.d = d;
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #6;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        sync();
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int w;
        wr_valid = 1'b0;
        wr_addr  = 4'd0;
        wr_data  = 16'h0000;
        hold     = 1'b0;
        rd_addr  = 4'd0;
        reset_n  = 1'b0;
        clear_model();

        // Reset state
        #2;
        chk("rst_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        #5;
        reset_n = 1'b1;
        sync();

        // Single write, forwarded before commit and stored after
        do_write(4'd5, 16'hBEEF, w);
        chk("w5_wait", 32'(w), 32'd0);
        idle();
        rd_chk("w5_fwd", 4'd5, 16'hBEEF);
        sync();
        chk("w5_strobe", 32'(wr_strobe), 32'h0020);
        chk("w5_count", 32'(wr_count), 32'd1);
        rd_chk("w5_commit_rd", 4'd5, 16'hBEEF);
        sync();
        chk("w5_strobe_off", 32'(wr_strobe), 32'd0);
        drain();
        rd_chk("w5_after", 4'd5, 16'hBEEF);

        // Back-to-back writes, same address twice
        do_reset();
        do_write(4'd0, 16'h0001, w);
        chk("b2b_ready0", 32'(w), 32'd0);
        do_write(4'd15, 16'h0002, w);
        chk("b2b_ready1", 32'(w), 32'd0);
        do_write(4'd0, 16'h0003, w);
        chk("b2b_ready2", 32'(w), 32'd0);
        idle();
        drain();
        rd_chk("b2b_r0", 4'd0, 16'h0003);
        rd_chk("b2b_r15", 4'd15, 16'h0002);
        chk("b2b_count", 32'(wr_count), 32'd3);

        // Hold: accepted into empty slot, then blocks until released
        do_reset();
        hold = 1'b1;
        do_write(4'd7, 16'h1234, w);
        chk("hold_accept_wait", 32'(w), 32'd0);
        idle();
        @(negedge clk);
        chk("hold_ready", 32'(wr_ready), 32'd0);
        chk("hold_no_strobe", 32'(wr_strobe), 32'd0);
        rd_chk("hold_fwd", 4'd7, 16'h1234);
        sync();
        sync();
        chk("hold_no_strobe2", 32'(wr_strobe), 32'd0);
        chk("hold_count", 32'(wr_count), 32'd0);
        hold = 1'b0;
        sync();
        chk("hold_rel_strobe", 32'(wr_strobe), 32'h0080);
        chk("hold_rel_ready", 32'(wr_ready), 32'd1);
        drain();
        rd_chk("hold_r7", 4'd7, 16'h1234);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            do_write(4'(i), 16'(i * 7 + 1), w);
        end
        idle();
        drain();
        chk("wrap_256", 32'(wr_count), 32'd0);
        do_write(4'd9, 16'h0BAD, w);
        idle();
        drain();
        chk("wrap_257", 32'(wr_count), 32'd1);

        // Reset while an entry is staged
        do_reset();
        do_write(4'd3, 16'h5555, w);
        idle();
        drain();
        hold = 1'b1;
        do_write(4'd3, 16'hAAAA, w);
        idle();
        rd_chk("rst_stage_fwd", 4'd3, 16'hAAAA);
        chk("rst_stage_cnt", 32'(wr_count), 32'd1);
        #1;
        reset_n = 1'b0;
        clear_model();
        #1;
        chk("rst_mid_rd", 32'(rd_data), 32'd0);
        chk("rst_mid_count", 32'(wr_count), 32'd0);
        chk("rst_mid_strobe", 32'(wr_strobe), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        hold    = 1'b0;
        repeat (3) begin
            sync();
            chk("rst_after_strobe", 32'(wr_strobe), 32'd0);
        end
        rd_chk("rst_after_r3", 4'd3, 16'h0000);
        chk("rst_after_count", 32'(wr_count), 32'd0);
        sync();

        // wr_valid low: address/data must be ignored
        do_write(4'd1, 16'h1111, w);
        do_write(4'd2, 16'h2222, w);
        idle();
        drain();
        for (int i = 0; i < 10; i++) begin
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            sync();
            chk("novld_strobe", 32'(wr_strobe), 32'd0);
        end
        chk("novld_count", 32'(wr_count), 32'(model_cnt));
        chk("novld_count_abs", 32'(wr_count), 32'd2);
        for (int i = 0; i < 16; i++) begin
            rd_chk("novld_reg", 4'(i), model_mem[i]);
        end
        sync();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
